lm_sm_sequencer: RTL and testbench

- Multi-cycle controller for the Load-Multiple (LM) and Store-Multiple (SM) instructions of the iitb_risc pipeline.
- Accepts one decoded LM/SM instruction and the base register value.
- Emits one register/memory micro-op per cycle to the RR/EX/MEM stages.
- Holds instruction fetch and decode until the register list is exhausted.

---
 rtl/lm_sm_sequencer.sv | 102 ++++++++++
 tb/tb_lm_sm_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer: multi-cycle LM/SM micro-op sequencer for iitb_risc.
// Ports: clk, reset (async active-low), start/instr/base_addr from decode,
//   stall_in from downstream; busy, hold_fetch, uop_* micro-op bundle, done.
module lm_sm_sequencer #(
    parameter logic [3:0] LM_OPCODE = 4'b0110,
    parameter logic [3:0] SM_OPCODE = 4'b0111,
    parameter int         ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       instr,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              stall_in,
    output logic              busy,
    output logic              hold_fetch,
    output logic              uop_valid,
    output logic              uop_is_load,
    output logic [2:0]        uop_reg,
    output logic [ADDR_W-1:0] uop_addr,
    output logic              uop_last,
    output logic              done
);

    typedef enum logic {IDLE, SEQ} state_t;

    state_t            state;
    logic [7:0]        mask;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] offset;
    logic              is_ld;

    logic [3:0] op;
    logic       accept;
    logic       one_left;
    logic [2:0] low_idx;
    logic       unused_bits;

    assign op          = instr[15:12];
    assign unused_bits = ^instr[11:8];
    assign accept      = (state == IDLE) && start &&
                         (op == LM_OPCODE || op == SM_OPCODE);

    // Exactly one bit set: clearing the lowest set bit leaves zero.
    assign one_left = (mask != 8'd0) && ((mask & (mask - 8'd1)) == 8'd0);

    // Scan high to low so the lowest set bit wins.
    always_comb begin
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) low_idx = 3'(i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            mask   <= 8'd0;
            base   <= '0;
            offset <= '0;
            is_ld  <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (instr[7:0] == 8'd0) begin
                            done <= 1'b1;
                        end else begin
                            mask   <= instr[7:0];
                            base   <= base_addr;
                            is_ld  <= (op == LM_OPCODE);
                            offset <= '0;
                            state  <= SEQ;
                        end
                    end
                end
                SEQ: begin
                    if (!stall_in) begin
                        mask   <= mask & (mask - 8'd1);
                        offset <= offset + ADDR_W'(1);
                        if (one_left) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy        = (state == SEQ);
    assign uop_valid   = busy;
    assign hold_fetch  = accept || busy;
    assign uop_is_load = busy && is_ld;
    assign uop_last    = busy && one_left;
    assign uop_reg     = busy ? low_idx : 3'd0;
    assign uop_addr    = busy ? (base + offset) : '0;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// tb_lm_sm_sequencer: directed scoreboard bench for lm_sm_sequencer.
// Stimulus pushes expected micro-ops/done cycles; a negedge monitor checks.
module tb_lm_sm_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] instr;
    logic [15:0] base_addr;
    logic        stall_in;
    logic        busy, hold_fetch, uop_valid, uop_is_load;
    logic [2:0]  uop_reg;
    logic [15:0] uop_addr;
    logic        uop_last, done;

    lm_sm_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .instr(instr),
        .base_addr(base_addr), .stall_in(stall_in), .busy(busy),
        .hold_fetch(hold_fetch), .uop_valid(uop_valid),
        .uop_is_load(uop_is_load), .uop_reg(uop_reg),
        .uop_addr(uop_addr), .uop_last(uop_last), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  r;
        logic [15:0] a;
        logic        ld;
        logic        last;
        int          c;
    } uop_t;

    uop_t exp_q[$];
    int   done_q[$];
    int   cyc = 0;
    int   nchecks = 0;
    int   nerr = 0;
    int   stall_seen = 0;
    uop_t e;
    int   dc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares every presented micro-op and done pulse.
    always @(negedge clk) begin
        if (reset) begin
            if (uop_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_uop", 1, 0);
                end else begin
                    e = exp_q[0];
                    check("uop_reg", uop_reg, e.r);
                    check("uop_addr", uop_addr, e.a);
                    check("uop_is_load", uop_is_load, e.ld);
                    check("uop_last", uop_last, e.last);
                    check("busy_hold", {busy, hold_fetch}, 2'b11);
                    if (stall_in) begin
                        stall_seen++;
                    end else begin
                        check("uop_cycle", cyc, e.c);
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                check("idle_outs",
                      {busy, uop_is_load, uop_last, uop_reg, uop_addr},
                      0);
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    dc = done_q.pop_front();
                    check("done_cycle", cyc, dc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] r, input logic [15:0] a,
                        input logic ld, input logic last, input int c);
        uop_t u;
        u.r = r; u.a = a; u.ld = ld; u.last = last; u.c = c;
        exp_q.push_back(u);
    endtask

    task automatic go(input logic [15:0] ins, input logic [15:0] b);
        start = 1'b1; instr = ins; base_addr = b;
        #1;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0 || busy) &&
               n < 60) begin
            tick();
            n++;
        end
        check({nm, "_drained"}, (n < 60), 1);
        exp_q.delete();
        done_q.delete();
    endtask

    int k;

    initial begin
        reset = 1'b0; start = 1'b0; instr = '0;
        base_addr = '0; stall_in = 1'b0;
        #12;
        check("reset_outs",
              {busy, hold_fetch, uop_valid, uop_is_load, uop_last,
               uop_reg, uop_addr, done}, 0);
        tick();
        reset = 1'b1;
        tick();

        // LM 0x60ae from base 5: R1,R2,R3,R5,R7
        k = cyc;
        push(1, 16'h0005, 1, 0, k + 1);
        push(2, 16'h0006, 1, 0, k + 2);
        push(3, 16'h0007, 1, 0, k + 3);
        push(5, 16'h0008, 1, 0, k + 4);
        push(7, 16'h0009, 1, 1, k + 5);
        done_q.push_back(k + 6);
        go(16'h60ae, 16'h0005);
        check("lm_accept_hold", hold_fetch, 1);
        tick();
        start = 1'b0;
        drain("lm");

        // SM full list, R2 stalled for two cycles
        k = cyc;
        stall_seen = 0;
        push(0, 16'h0010, 0, 0, k + 1);
        push(1, 16'h0011, 0, 0, k + 2);
        push(2, 16'h0012, 0, 0, k + 5);
        push(3, 16'h0013, 0, 0, k + 6);
        push(4, 16'h0014, 0, 0, k + 7);
        push(5, 16'h0015, 0, 0, k + 8);
        push(6, 16'h0016, 0, 0, k + 9);
        push(7, 16'h0017, 0, 1, k + 10);
        done_q.push_back(k + 11);
        go(16'h70ff, 16'h0010);
        tick();
        start = 1'b0;
        tick();
        tick();
        stall_in = 1'b1;
        tick();
        tick();
        stall_in = 1'b0;
        drain("sm");
        check("sm_stall_cycles", stall_seen, 2);

        // Address wrap with R0 and R7
        k = cyc;
        push(0, 16'hFFFF, 1, 0, k + 1);
        push(7, 16'h0000, 1, 1, k + 2);
        done_q.push_back(k + 3);
        go(16'h6081, 16'hFFFF);
        tick();
        start = 1'b0;
        drain("wrap");

        // Zero list: done only
        k = cyc;
        done_q.push_back(k + 1);
        go(16'h6000, 16'h1234);
        check("zero_accept_hold", hold_fetch, 1);
        tick();
        start = 1'b0;
        check("zero_not_busy", busy, 0);
        drain("zero");

        // Illegal opcode ignored
        go(16'h1234, 16'h0000);
        check("illegal_hold", hold_fetch, 0);
        tick();
        start = 1'b0;
        check("illegal_busy", busy, 0);
        tick();
        check("illegal_busy2", busy, 0);

        // Reset during the second micro-op of LM 0x60ff
        k = cyc;
        push(0, 16'h0020, 1, 0, k + 1);
        push(1, 16'h0021, 1, 0, k + 2);
        go(16'h60ff, 16'h0020);
        tick();
        start = 1'b0;
        tick();
        check("pre_reset_reg", uop_reg, 1);
        reset = 1'b0;
        #1;
        check("abort_outs", {busy, hold_fetch, uop_valid}, 0);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("post_reset_busy", busy, 0);
        k = cyc;
        push(0, 16'h0040, 1, 0, k + 1);
        push(1, 16'h0041, 1, 1, k + 2);
        done_q.push_back(k + 3);
        go(16'h6003, 16'h0040);
        tick();
        start = 1'b0;
        drain("after_reset");

        // Back-to-back: second start lands on the done cycle
        k = cyc;
        push(0, 16'h0050, 1, 0, k + 1);
        push(1, 16'h0051, 1, 1, k + 2);
        done_q.push_back(k + 3);
        push(0, 16'h0060, 1, 0, k + 4);
        push(1, 16'h0061, 1, 1, k + 5);
        done_q.push_back(k + 6);
        go(16'h6003, 16'h0050);
        tick();
        start = 1'b0;
        tick();
        tick();
        check("b2b_done_now", done, 1);
        go(16'h6003, 16'h0060);
        check("b2b_accept_hold", hold_fetch, 1);
        tick();
        start = 1'b0;
        drain("b2b");

        $display("Simulation finished: %0d checks, %0d errors",
                 nchecks, nerr);
        $finish;
    end

endmodule
